// File: rtl/fetch_stage_if.sv
// =============================================================================
// Module      : fetch_stage_if
// Description : Signal bundle between the fetch stage and its surroundings:
//               downstream hazard/branch control, instruction memory and the
//               IF/ID hand-off to decode.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

interface fetch_stage_if;
    // Control from downstream hazard and branch-resolution logic
    logic        stall;
    logic        redirect;
    logic [15:0] redirectPC;

    // Instruction memory (combinational read of imemAddr)
    logic [15:0] imemAddr;
    logic [15:0] imemData;

    // Hand-off to decode and status
    logic [15:0] instr;
    logic [15:0] pcPlus2;
    logic        valid;
    logic        fetchHalted;
    logic        err;

    // The fetch stage itself: issues addresses, produces the decode hand-off
    modport master (
        input  stall,
        input  redirect,
        input  redirectPC,
        input  imemData,
        output imemAddr,
        output instr,
        output pcPlus2,
        output valid,
        output fetchHalted,
        output err
    );

    // Environment: control logic, memory model and decode
    modport slave (
        output stall,
        output redirect,
        output redirectPC,
        output imemData,
        input  imemAddr,
        input  instr,
        input  pcPlus2,
        input  valid,
        input  fetchHalted,
        input  err
    );
endinterface : fetch_stage_if

`default_nettype wire

// File: rtl/fetch_stage.sv
// =============================================================================
// Module      : fetch_stage
// Description : Instruction fetch stage. Holds the 16-bit PC, a RUN/HALTED
//               FSM and a sticky misaligned-redirect flag. Opcode field
//               imemData[15:11] == 0 is HALT: it is handed to decode once,
//               then the stage parks on that PC until redirected.
//               Optional feature macro FETCH_IFID_REG_EN: when defined, the
//               decode hand-off (instr/pcPlus2/valid) comes from an IF/ID
//               register (one cycle after imemData); when undefined it is
//               driven combinationally from the current fetch.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module fetch_stage (
    input  wire logic      clk,
    input  wire logic      rst,
    fetch_stage_if.master  bus
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [15:0] c_NOP_INSTR = 16'h0800;   // bubble instruction
    localparam logic [15:0] c_PC_RESET  = 16'h0000;
    localparam logic [15:0] c_PC_STEP   = 16'd2;
    localparam logic [4:0]  c_HALT_OPC  = 5'b00000;

    typedef enum logic [0:0] {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_t;

    // -------------------------------------------------------------------------
    // State and next-state signals
    // -------------------------------------------------------------------------
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_pc;
    logic [15:0] w_pc_next;
    logic [15:0] w_pc_plus2;
    logic        r_err;
    logic        w_err_next;
    logic        w_is_halt;

    // Address of the word after the current fetch; wraps naturally at 2^16
    assign w_pc_plus2 = r_pc + c_PC_STEP;
    assign w_is_halt  = (bus.imemData[15:11] == c_HALT_OPC);

    // Next-state logic: redirect beats stall, stall beats halt detection,
    // halt detection beats sequential advance
    always_comb begin
        w_state_next = r_state;
        w_pc_next    = r_pc;
        w_err_next   = r_err;

        if (bus.redirect) begin
            // A HALT fetched in this same cycle is discarded by going to RUN
            w_pc_next    = bus.redirectPC;
            w_state_next = RUN;
            w_err_next   = r_err | bus.redirectPC[0];
        end else if (!bus.stall) begin
            if (r_state == RUN) begin
                if (w_is_halt) begin
                    // PC parks on the HALT word so a later restart is easy to trace
                    w_state_next = HALTED;
                end else begin
                    w_pc_next = w_pc_plus2;
                end
            end
        end
    end

    // State register: PC, FSM state and sticky error flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RUN;
            r_pc    <= c_PC_RESET;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_pc    <= w_pc_next;
            r_err   <= w_err_next;
        end
    end

    assign bus.imemAddr    = r_pc;
    assign bus.fetchHalted = (r_state == HALTED);
    assign bus.err         = r_err;

`ifdef FETCH_IFID_REG_EN
    // -------------------------------------------------------------------------
    // Registered IF/ID hand-off
    // -------------------------------------------------------------------------
    logic [15:0] r_ifid_instr;
    logic [15:0] r_ifid_pc_plus2;
    logic        r_ifid_valid;

    // IF/ID register: bubble on reset/redirect/halted, hold on stall,
    // otherwise capture the word fetched in RUN (including a HALT word)
    always_ff @(posedge clk) begin
        if (rst || bus.redirect) begin
            r_ifid_instr    <= c_NOP_INSTR;
            r_ifid_pc_plus2 <= 16'h0000;
            r_ifid_valid    <= 1'b0;
        end else if (!bus.stall) begin
            if (r_state == RUN) begin
                r_ifid_instr    <= bus.imemData;
                r_ifid_pc_plus2 <= w_pc_plus2;
                r_ifid_valid    <= 1'b1;
            end else begin
                r_ifid_instr    <= c_NOP_INSTR;
                r_ifid_pc_plus2 <= 16'h0000;
                r_ifid_valid    <= 1'b0;
            end
        end
    end

    assign bus.instr   = r_ifid_instr;
    assign bus.pcPlus2 = r_ifid_pc_plus2;
    assign bus.valid   = r_ifid_valid;
`else
    // -------------------------------------------------------------------------
    // Combinational hand-off: the current fetch goes straight to decode
    // -------------------------------------------------------------------------
    logic w_bubble;

    // A redirect in flight makes the current word a wrong-path fetch
    assign w_bubble    = (r_state == HALTED) || bus.redirect;
    assign bus.instr   = w_bubble ? c_NOP_INSTR : bus.imemData;
    assign bus.pcPlus2 = w_bubble ? 16'h0000    : w_pc_plus2;
    assign bus.valid   = ~w_bubble;
`endif

endmodule : fetch_stage

`default_nettype wire

// File: tb/tb_fetch_stage.sv
// =============================================================================
// Module      : tb_fetch_stage
// Description : Self-checking bench for fetch_stage. A behavioural model of
//               the fetch rules (PC, halted flag, sticky err, IF/ID contents)
//               predicts every output; directed scenarios plus randomized
//               stall/redirect/reset traffic over a randomized memory.
// Revision    : 1.0 - initial release
// =============================================================================
`default_nettype none

module tb_fetch_stage;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fetch_stage_if bus ();

    fetch_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Instruction memory indexed by the full byte address
    logic [15:0] mem [0:65535];
    assign bus.imemData = mem[bus.imemAddr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // -------------------------------------------------------------------------
    // Reference model state
    // -------------------------------------------------------------------------
    logic [15:0] m_pc;
    logic        m_halted;
    logic        m_err;
    logic [15:0] m_instr;
    logic [15:0] m_pp2;
    logic        m_valid;

    function automatic logic [15:0] rand_word(input bit halt);
        logic [15:0] w;
        w = 16'($urandom);
        if (halt) w[15:11] = 5'b00000;
        else      w[15:11] = 5'($urandom_range(1, 31));
        return w;
    endfunction

    // Expected {imemAddr, instr, pcPlus2, valid, fetchHalted, err}
    function automatic logic [50:0] exp_vec();
        logic [15:0] ei;
        logic [15:0] ep;
        logic        ev;
`ifdef FETCH_IFID_REG_EN
        ei = m_instr;
        ep = m_pp2;
        ev = m_valid;
`else
        if (m_halted || bus.redirect) begin
            ei = 16'h0800; ep = 16'h0000; ev = 1'b0;
        end else begin
            ei = mem[m_pc]; ep = m_pc + 16'd2; ev = 1'b1;
        end
`endif
        return {m_pc, ei, ep, ev, m_halted, m_err};
    endfunction

    // Apply one cycle of inputs, advance the clock and update the model
    task automatic step(input logic rs, input logic s, input logic r, input logic [15:0] rpc);
        logic [15:0] w;
        logic [15:0] n_pc, n_instr, n_pp2;
        logic        n_halted, n_err, n_valid;
        rst = rs; bus.stall = s; bus.redirect = r; bus.redirectPC = rpc;
        #1;
        w = mem[m_pc];
        n_pc = m_pc; n_halted = m_halted; n_err = m_err;
        n_instr = m_instr; n_pp2 = m_pp2; n_valid = m_valid;
        if (rs) begin
            n_pc = 16'h0000; n_halted = 1'b0; n_err = 1'b0;
            n_instr = 16'h0800; n_pp2 = 16'h0000; n_valid = 1'b0;
        end else if (r) begin
            n_pc = rpc; n_halted = 1'b0; n_err = m_err | rpc[0];
            n_instr = 16'h0800; n_pp2 = 16'h0000; n_valid = 1'b0;
        end else if (!s) begin
            if (!m_halted) begin
                n_instr = w; n_pp2 = m_pc + 16'd2; n_valid = 1'b1;
                if (w[15:11] == 5'd0) n_halted = 1'b1;
                else                  n_pc = m_pc + 16'd2;
            end else begin
                n_instr = 16'h0800; n_pp2 = 16'h0000; n_valid = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_pc = n_pc; m_halted = n_halted; m_err = n_err;
        m_instr = n_instr; m_pp2 = n_pp2; m_valid = n_valid;
    endtask

    task automatic test_reset();
        logic [50:0] obs, exp;
        step(1'b1, 1'b1, 1'b1, 16'h0033);
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        exp = exp_vec();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL reset_vec got=%h exp=%h", obs, exp); end
        checks++;
        if ({bus.imemAddr, bus.fetchHalted, bus.err} !== {16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h/%b/%b exp=0000/0/0", bus.imemAddr, bus.fetchHalted, bus.err);
        end
`ifdef FETCH_IFID_REG_EN
        checks++;
        if ({bus.instr, bus.pcPlus2, bus.valid} !== {16'h0800, 16'h0000, 1'b0}) begin
            failures++;
            $display("FAIL reset_bubble got=%h/%h/%b exp=0800/0000/0", bus.instr, bus.pcPlus2, bus.valid);
        end
`endif
    endtask

    task automatic test_sequential();
        logic [50:0] obs, exp;
        logic [15:0] want_pc [3];
        mem[0] = 16'h4000; mem[2] = 16'h4100; mem[4] = 16'h4200; mem[6] = 16'h0000;
        want_pc = '{16'h0000, 16'h0002, 16'h0004};
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            if (i > 0) step(1'b0, 1'b0, 1'b0, 16'h0000);
            obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL seq_vec[%0d] got=%h exp=%h", i, obs, exp); end
            checks++;
            if (bus.imemAddr !== want_pc[i]) begin
                failures++; $display("FAIL seq_pc[%0d] got=%h exp=%h", i, bus.imemAddr, want_pc[i]);
            end
        end
`ifdef FETCH_IFID_REG_EN
        checks++;
        if ({bus.instr, bus.valid} !== {16'h4100, 1'b1}) begin
            failures++; $display("FAIL seq_instr got=%h/%b exp=4100/1", bus.instr, bus.valid);
        end
`endif
    endtask

    task automatic test_stall();
        logic [50:0] obs, exp, frozen;
        frozen = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 1'b0, 16'h0000);
            obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL stall_vec[%0d] got=%h exp=%h", i, obs, exp); end
            checks++;
            if (bus.imemAddr !== 16'h0004) begin
                failures++; $display("FAIL stall_pc[%0d] got=%h exp=0004", i, bus.imemAddr);
            end
        end
`ifdef FETCH_IFID_REG_EN
        obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        checks++;
        if (obs !== frozen) begin failures++; $display("FAIL stall_frozen got=%h exp=%h", obs, frozen); end
`endif
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        checks++;
        if (bus.imemAddr !== 16'h0006) begin
            failures++; $display("FAIL stall_release got=%h exp=0006", bus.imemAddr);
        end
    endtask

    task automatic test_halt();
        logic [50:0] obs, exp;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL halt_vec[%0d] got=%h exp=%h", i, obs, exp); end
            checks++;
            if ({bus.imemAddr, bus.fetchHalted} !== {16'h0006, 1'b1}) begin
                failures++; $display("FAIL halt_state[%0d] got=%h/%b exp=0006/1", i, bus.imemAddr, bus.fetchHalted);
            end
        end
    endtask

    task automatic test_redirect();
        logic [50:0] obs, exp;
        mem[16'h0020] = 16'h5000;
        mem[16'h0022] = 16'h5100;
        step(1'b0, 1'b0, 1'b1, 16'h0020);
        bus.redirect = 1'b0;
        #1;
        obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        exp = exp_vec();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL redir_vec got=%h exp=%h", obs, exp); end
        checks++;
        if ({bus.imemAddr, bus.fetchHalted} !== {16'h0020, 1'b0}) begin
            failures++; $display("FAIL redir_state got=%h/%b exp=0020/0", bus.imemAddr, bus.fetchHalted);
        end
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        exp = exp_vec();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL redir_fetch got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_err();
        logic [50:0] obs, exp;
        mem[16'h0011] = 16'h6000; mem[16'h0013] = 16'h6100; mem[16'h0015] = 16'h6200;
        step(1'b0, 1'b1, 1'b1, 16'h0011);
        checks++;
        if ({bus.imemAddr, bus.err} !== {16'h0011, 1'b1}) begin
            failures++; $display("FAIL err_set got=%h/%b exp=0011/1", bus.imemAddr, bus.err);
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 1'b0, 16'h0000);
            obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin failures++; $display("FAIL err_sticky[%0d] got=%h exp=%h", i, obs, exp); end
        end
    endtask

    task automatic test_wrap();
        logic [50:0] obs, exp;
        mem[16'hFFFE] = 16'h7000;
        mem[16'h0000] = 16'h4000;
        step(1'b0, 1'b0, 1'b1, 16'hFFFE);
        step(1'b0, 1'b0, 1'b0, 16'h0000);
        obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        exp = exp_vec();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL wrap_vec got=%h exp=%h", obs, exp); end
        checks++;
        if (bus.imemAddr !== 16'h0000) begin failures++; $display("FAIL wrap_pc got=%h exp=0000", bus.imemAddr); end
`ifdef FETCH_IFID_REG_EN
        checks++;
        if ({bus.instr, bus.pcPlus2} !== {16'h7000, 16'h0000}) begin
            failures++; $display("FAIL wrap_pp2 got=%h/%h exp=7000/0000", bus.instr, bus.pcPlus2);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [50:0] obs, exp;
        mem[16'h0040] = 16'h0123;           // HALT word, discarded by redirect
        mem[16'h0080] = 16'h4444;
        mem[16'h0100] = 16'h5555;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        step(1'b0, 1'b0, 1'b1, 16'h0040);
        step(1'b0, 1'b0, 1'b1, 16'h0080);    // redirect while HALT is on imemData
        checks++;
        if ({bus.imemAddr, bus.fetchHalted, bus.err} !== {16'h0080, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL b2b_halt_discard got=%h/%b/%b exp=0080/0/0", bus.imemAddr, bus.fetchHalted, bus.err);
        end
        step(1'b0, 1'b0, 1'b1, 16'h0100);
        obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
        exp = exp_vec();
        checks++;
        if (obs !== exp) begin failures++; $display("FAIL b2b_vec got=%h exp=%h", obs, exp); end
    endtask

    task automatic test_random();
        logic [50:0] obs, exp;
        logic        rs, s, r;
        logic [15:0] rpc;
        int          errs;
        errs = 0;
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        for (int i = 0; i < 500; i++) begin
            rs  = ($urandom_range(0, 99) < 2);
            s   = ($urandom_range(0, 99) < 20);
            r   = ($urandom_range(0, 99) < 10);
            rpc = 16'($urandom) & 16'h00FE;
            if ($urandom_range(0, 99) < 10) rpc[0] = 1'b1;
            if ($urandom_range(0, 99) < 5)  rpc = 16'hFFFE;
            step(rs, s, r, rpc);
            obs = {bus.imemAddr, bus.instr, bus.pcPlus2, bus.valid, bus.fetchHalted, bus.err};
            exp = exp_vec();
            checks++;
            if (obs !== exp) begin
                failures++;
                if (errs < 10) $display("FAIL rand_vec[%0d] got=%h exp=%h", i, obs, exp);
                errs++;
            end
        end
        step(1'b1, 1'b0, 1'b0, 16'h0000);
        checks++;
        if ({bus.imemAddr, bus.fetchHalted, bus.err} !== {16'h0000, 1'b0, 1'b0}) begin
            failures++;
            $display("FAIL rand_final_reset got=%h/%b/%b exp=0000/0/0", bus.imemAddr, bus.fetchHalted, bus.err);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        rst = 1'b1; bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirectPC = 16'h0000;
        m_pc = 16'h0000; m_halted = 1'b0; m_err = 1'b0;
        m_instr = 16'h0800; m_pp2 = 16'h0000; m_valid = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = rand_word($urandom_range(0, 99) < 8);
        @(posedge clk); #1;
        test_reset();
        test_sequential();
        test_stall();
        test_halt();
        test_redirect();
        test_err();
        test_wrap();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_fetch_stage

`default_nettype wire
